// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the skewed-counter monitor.
// Holds the tracking state encoding, counter width constants and the saturating increment.
package count_mon_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } mon_state_t;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Holds at max_v instead of wrapping; callers truncate to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/count_mon_snap.sv
// Snapshot register: captures i_data on request and holds it until the consumer accepts.
// Latency 1 cycle req->valid; a request arriving while a snapshot is held and not accepted is dropped and flagged sticky.
module count_mon_snap #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_ready,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_overrun
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_overrun;
    logic              w_accept;
    logic              w_load;
    logic              w_drop;

    // Acceptance frees the register in the same cycle, so a coincident request reloads it.
    assign w_accept = r_valid && i_ready;
    assign w_load   = i_req && (!r_valid || i_ready);
    assign w_drop   = i_req && r_valid && !i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (i_clr) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/count_skew_monitor.sv
// Checks that each sample of a skewed 16-bit counter is the previous sample plus one.
// Counts increment/rollover errors and wraps; snapshots returned over valid/ready.
module count_skew_monitor
    import count_mon_pkg::*;
#(
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 16,
    parameter int WRAP_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [CNT_W-1:0]       i_q,
    input  logic                   i_rollover,
    input  logic                   i_clr_err,
    input  logic                   i_snap_req,
    input  logic                   i_snap_ready,
    output logic                   o_snap_valid,
    output logic [CNT_W+ERR_W-1:0] o_snap_data,
    output logic [ERR_W-1:0]       o_err_count,
    output logic [ERR_W-1:0]       o_roll_err_count,
    output logic [WRAP_W-1:0]      o_wrap_count,
    output logic                   o_locked,
    output logic                   o_snap_overrun
);

    localparam logic [31:0] ERR_MAX  = 32'((64'd1 << ERR_W) - 64'd1);
    localparam logic [3:0]  RUN_LAST = 4'(LOCK_N - 1);

    logic [CNT_W-1:0]  r_s1_q;
    logic              r_s1_roll;
    logic [CNT_W-1:0]  r_s2_q;
    mon_state_t        r_state;
    mon_state_t        w_state_nxt;
    logic [3:0]        r_run;
    logic [3:0]        w_run_nxt;
    logic [ERR_W-1:0]  r_err;
    logic [ERR_W-1:0]  r_roll_err;
    logic [WRAP_W-1:0] r_wrap;
    logic [CNT_W-1:0]  w_exp;
    logic              w_good;
    logic              w_track;
    logic              w_err_inc;
    logic              w_roll_bad;
    logic              w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_q    <= '0;
            r_s1_roll <= 1'b0;
            r_s2_q    <= '0;
        end else begin
            r_s1_q    <= i_q;
            r_s1_roll <= i_rollover;
            r_s2_q    <= r_s1_q;
        end
    end

    assign w_exp  = r_s2_q + 16'd1;
    assign w_good = (r_s1_q == w_exp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
        if (!i_rst_n) begin
            r_state <= ACQ;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // ACQ and RESYNC share the same lock-in rule; only TRACK counts errors.
    always_comb begin : next_state
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        case (r_state)
            TRACK: begin
                if (!w_good) begin
                    w_state_nxt = RESYNC;
                    w_run_nxt   = '0;
                end
            end
            ACQ, RESYNC: begin
                if (!w_good) begin
                    w_run_nxt = '0;
                end else if (r_run == RUN_LAST) begin
                    w_state_nxt = TRACK;
                    w_run_nxt   = '0;
                end else begin
                    w_run_nxt = r_run + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ACQ;
                w_run_nxt   = '0;
            end
        endcase
    end

    always_comb begin : out_comb
        w_track    = (r_state == TRACK);
        w_err_inc  = w_track && !w_good;
        w_roll_bad = w_track && (r_s1_roll != (r_s1_q == CNT_MAX));
        w_wrap     = w_track && w_good && (r_s2_q == CNT_MAX);
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err      <= '0;
            r_roll_err <= '0;
            r_wrap     <= '0;
        end else begin
            if (i_clr_err) begin
                r_err <= '0;
            end else if (w_err_inc) begin
                r_err <= ERR_W'(sat_inc(32'(r_err), ERR_MAX));
            end
            if (i_clr_err) begin
                r_roll_err <= '0;
            end else if (w_roll_bad) begin
                r_roll_err <= ERR_W'(sat_inc(32'(r_roll_err), ERR_MAX));
            end
            if (w_wrap) begin
                r_wrap <= r_wrap + WRAP_W'(1);
            end
        end
    end

    count_mon_snap #(
        .DATA_W (CNT_W + ERR_W)
    ) u_snap (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_snap_req),
        .i_ready   (i_snap_ready),
        .i_clr     (i_clr_err),
        .i_data    ({r_s1_q, r_err}),
        .o_valid   (o_snap_valid),
        .o_data    (o_snap_data),
        .o_overrun (o_snap_overrun)
    );

    assign o_err_count      = r_err;
    assign o_roll_err_count = r_roll_err;
    assign o_wrap_count     = r_wrap;
    assign o_locked         = w_track;

endmodule

// File: tb/tb_count_skew_monitor.sv
// Directed plus randomized bench for count_skew_monitor against a sample-history reference model.
module tb_count_skew_monitor;

    localparam int LP_LOCK   = 4;
    localparam int LP_ERR_W  = 5;
    localparam int LP_WRAP_W = 8;
    localparam int LP_ERRMAX = (1 << LP_ERR_W) - 1;

    logic                  clk;
    logic                  rst_n;
    logic [15:0]           q;
    logic                  rollover;
    logic                  clr_err;
    logic                  snap_req;
    logic                  snap_ready;
    logic                  snap_valid;
    logic [16+LP_ERR_W-1:0] snap_data;
    logic [LP_ERR_W-1:0]   err_count;
    logic [LP_ERR_W-1:0]   roll_err_count;
    logic [LP_WRAP_W-1:0]  wrap_count;
    logic                  locked;
    logic                  snap_overrun;

    count_skew_monitor #(
        .LOCK_N (LP_LOCK),
        .ERR_W  (LP_ERR_W),
        .WRAP_W (LP_WRAP_W)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_q              (q),
        .i_rollover       (rollover),
        .i_clr_err        (clr_err),
        .i_snap_req       (snap_req),
        .i_snap_ready     (snap_ready),
        .o_snap_valid     (snap_valid),
        .o_snap_data      (snap_data),
        .o_err_count      (err_count),
        .o_roll_err_count (roll_err_count),
        .o_wrap_count     (wrap_count),
        .o_locked         (locked),
        .o_snap_overrun   (snap_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the last two samples taken, whether we are tracking, and the visible counters.
    int     m_new_q, m_old_q;
    bit     m_new_roll;
    bit     m_trk;
    int     m_run;
    int     m_err, m_rerr, m_wrap;
    bit     m_sv, m_ov;
    longint m_sd;

    logic [15:0] cq;
    logic [15:0] qv;
    logic        rv, cv, rqv, rdv;
    int          lock_at;
    int          exp_hi;

    task automatic model_reset();
        m_new_q = 0; m_old_q = 0; m_new_roll = 0;
        m_trk = 0; m_run = 0;
        m_err = 0; m_rerr = 0; m_wrap = 0;
        m_sv = 0; m_ov = 0; m_sd = 0;
    endtask

    task automatic model_edge(input int nq_in, input bit r_in, input bit c, input bit rq, input bit rd);
        bit good;
        int e, re, w, run;
        bit trk, sv_old;
        good = (m_new_q == ((m_old_q + 1) % 65536));
        e = m_err; re = m_rerr; w = m_wrap; trk = m_trk; run = m_run;
        if (m_trk) begin
            if (!good) begin
                e = (m_err < LP_ERRMAX) ? m_err + 1 : LP_ERRMAX;
                trk = 0;
                run = 0;
            end else if (m_old_q == 65535) begin
                w = (m_wrap + 1) % (1 << LP_WRAP_W);
            end
            if (m_new_roll != (m_new_q == 65535))
                re = (m_rerr < LP_ERRMAX) ? m_rerr + 1 : LP_ERRMAX;
        end else if (good) begin
            run = m_run + 1;
            if (run == LP_LOCK) begin
                trk = 1;
                run = 0;
            end
        end else begin
            run = 0;
        end
        if (c) begin
            e = 0;
            re = 0;
        end
        sv_old = m_sv;
        if (rq && (!m_sv || rd)) begin
            m_sd = (longint'(m_new_q) << LP_ERR_W) | longint'(m_err);
            m_sv = 1;
        end else if (m_sv && rd) begin
            m_sv = 0;
        end
        if (c) m_ov = 0;
        else if (rq && sv_old && !rd) m_ov = 1;
        m_err = e; m_rerr = re; m_wrap = w; m_trk = trk; m_run = run;
        m_old_q = m_new_q;
        m_new_q = nq_in;
        m_new_roll = r_in;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("snap_valid", 64'(snap_valid), 64'(m_sv));
        chk("snap_data", 64'(snap_data), 64'(m_sd));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("roll_err_count", 64'(roll_err_count), 64'(m_rerr));
        chk("wrap_count", 64'(wrap_count), 64'(m_wrap));
        chk("locked", 64'(locked), 64'(m_trk));
        chk("snap_overrun", 64'(snap_overrun), 64'(m_ov));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(snap_valid), 64'd0);
        chk({tag, "_data"}, 64'(snap_data), 64'd0);
        chk({tag, "_err"}, 64'(err_count), 64'd0);
        chk({tag, "_rerr"}, 64'(roll_err_count), 64'd0);
        chk({tag, "_wrap"}, 64'(wrap_count), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_ovr"}, 64'(snap_overrun), 64'd0);
    endtask

    task automatic step(input logic [15:0] sq, input logic sr, input logic sc, input logic srq, input logic srd);
        q = sq; rollover = sr; clr_err = sc; snap_req = srq; snap_ready = srd;
        @(posedge clk);
        model_edge(int'(sq), sr, sc, srq, srd);
        #1;
        check_all();
    endtask

    task automatic cnt(input int n);
        for (int k = 0; k < n; k++) begin
            step(cq, cq == 16'hFFFF, 1'b0, 1'b0, 1'b1);
            cq = cq + 16'd1;
        end
    endtask

    initial begin
        rst_n = 1'b0; q = '0; rollover = 1'b0; clr_err = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
        model_reset();
        #3;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst_n = 1'b1;

        // Clean count from zero through one full wrap.
        cq = 16'h0000;
        lock_at = -1;
        for (int i = 0; i < 70000; i++) begin
            cnt(1);
            if (lock_at < 0 && locked === 1'b1) lock_at = i + 1;
        end
        chk("lock_cycle", 64'(lock_at), 64'(LP_LOCK + 2));
        chk("clean_wrap", 64'(wrap_count), 64'd1);
        chk("clean_err", 64'(err_count), 64'd0);
        chk("clean_rerr", 64'(roll_err_count), 64'd0);

        // Upper nibble arrives early: 0x1234 seen as 0x2234.
        while (cq != 16'h1234) cnt(1);
        step(16'h2234, 1'b0, 1'b0, 1'b0, 1'b1);
        cq = cq + 16'd1;
        cnt(2);
        chk("skew_err", 64'(err_count), 64'd1);
        chk("skew_unlock", 64'(locked), 64'd0);
        cnt(6);
        chk("skew_relock", 64'(locked), 64'd1);

        // Rollover strobe missing at FFFF and spurious at 0005.
        cq = 16'hFFF0;
        cnt(8);
        step(cq, 1'b0, 1'b1, 1'b0, 1'b1);
        cq = cq + 16'd1;
        while (cq != 16'h0008) begin
            rv = (cq == 16'hFFFF) ? 1'b0 : (cq == 16'h0005);
            step(cq, rv, 1'b0, 1'b0, 1'b1);
            cq = cq + 16'd1;
        end
        cnt(3);
        chk("roll_errs", 64'(roll_err_count), 64'd2);
        chk("roll_inc_err", 64'(err_count), 64'd0);

        // Saturate err_count, then clear on a cycle that also sees a mismatch.
        for (int i = 0; i < LP_ERRMAX + 9; i++) begin
            cq = cq + 16'd1;
            cnt(LP_LOCK + 3);
        end
        chk("err_sat", 64'(err_count), 64'(LP_ERRMAX));
        cq = cq + 16'd1;
        cnt(1);
        step(cq, 1'b0, 1'b1, 1'b0, 1'b1);
        cq = cq + 16'd1;
        chk("clr_wins", 64'(err_count), 64'd0);

        // Snapshot at q=0x0100 held through backpressure, then back-to-back reload.
        cq = 16'h00F0;
        while (cq != 16'h0101) cnt(1);
        step(cq, 1'b0, 1'b0, 1'b1, 1'b0);
        cq = cq + 16'd1;
        for (int i = 0; i < 5; i++) begin
            step(cq, 1'b0, 1'b0, i == 2, 1'b0);
            cq = cq + 16'd1;
        end
        chk("snap_hold_q", 64'(snap_data[LP_ERR_W +: 16]), 64'h0100);
        chk("snap_ovr", 64'(snap_overrun), 64'd1);
        exp_hi = int'(cq) - 1;
        step(cq, 1'b0, 1'b0, 1'b1, 1'b1);
        cq = cq + 16'd1;
        chk("snap_b2b_vld", 64'(snap_valid), 64'd1);
        chk("snap_b2b_q", 64'(snap_data[LP_ERR_W +: 16]), 64'(exp_hi));
        step(cq, 1'b0, 1'b0, 1'b0, 1'b1);
        cq = cq + 16'd1;
        chk("snap_drain", 64'(snap_valid), 64'd0);

        // Randomized traffic across a wrap with glitches, bad strobes, clears and snapshots.
        cq = 16'hFE00;
        for (int i = 0; i < 3000; i++) begin
            qv = cq;
            if ($urandom_range(0, 39) == 0) qv = cq ^ {4'($urandom_range(1, 15)), 12'h000};
            rv = (qv == 16'hFFFF) ^ ($urandom_range(0, 49) == 0);
            cv = ($urandom_range(0, 59) == 0);
            rqv = ($urandom_range(0, 3) == 0);
            rdv = ($urandom_range(0, 1) == 0);
            step(qv, rv, cv, rqv, rdv);
            cq = cq + 16'd1;
        end

        // Asynchronous reset while a snapshot is pending in TRACK.
        cnt(LP_LOCK + 4);
        step(cq, 1'b0, 1'b0, 1'b1, 1'b0);
        cq = cq + 16'd1;
        chk("pre_rst_vld", 64'(snap_valid), 64'd1);
        chk("pre_rst_lock", 64'(locked), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt(3);
        chk("post_rst_acq", 64'(locked), 64'd0);
        cnt(LP_LOCK + 4);
        chk("post_rst_lock", 64'(locked), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
